frame_checker: RTL and testbench

Receive-side stage that consumes the AXIS frame stream returning from the device under test. This is the stream the frame generator's output produces after passing through the DUT and MAC.
Classifies each frame by axis_s_id and keeps per-port statistics: frames, bytes and errored frames. Software reads the statistics through a simple indexed read port.
Starts and stops counting on the same start/stop controls that drive the generator, so TX and RX windows line up.

---
 rtl/frame_checker_pkg.sv | 32 +++
 rtl/frame_checker_counter_bank.sv | 82 ++++++++
 rtl/frame_checker.sv | 217 +++++++++++++++++++++
 tb/tb_frame_checker.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/frame_checker_pkg.sv
// Shared types and helpers for the receive-side frame checker.
// Sequence checking is built only when FRAME_CHECKER_SEQ_CHECK_EN is defined.
package frame_checker_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    localparam int unsigned CNT_W    = 64;
    localparam int unsigned KEEP_MAX = 64;
    localparam int unsigned SEQ_LSB  = 352;
    localparam int unsigned SEQ_W    = 32;

    typedef struct packed {
        logic [CNT_W-1:0] frames;
        logic [CNT_W-1:0] bytes;
        logic [CNT_W-1:0] errors;
        logic [CNT_W-1:0] seq_errors;
    } counters_t;

    function automatic logic [7:0] popcount(input logic [KEEP_MAX-1:0] v);
        logic [7:0] n;
        n = '0;
        for (int unsigned i = 0; i < KEEP_MAX; i++) begin
            n = n + {7'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/frame_checker_counter_bank.sv
// Per-port saturating statistics counters with commit port, clear and registered readout.
// The seq_errors counter is live only when FRAME_CHECKER_SEQ_CHECK_EN is defined.
module frame_checker_counter_bank
    import frame_checker_pkg::*;
#(
    parameter int unsigned ID_WIDTH      = 3,
    parameter int unsigned COUNTER_WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     commit_valid,
    input  logic [ID_WIDTH-1:0]      commit_id,
    input  logic [15:0]              commit_len,
    input  logic                     commit_err,
`ifdef FRAME_CHECKER_SEQ_CHECK_EN
    input  logic                     commit_seq_err,
`endif
    input  logic [ID_WIDTH-1:0]      stat_sel,
    output logic [COUNTER_WIDTH-1:0] stat_frames,
    output logic [COUNTER_WIDTH-1:0] stat_bytes,
`ifdef FRAME_CHECKER_SEQ_CHECK_EN
    output logic [COUNTER_WIDTH-1:0] stat_seq_errors,
`endif
    output logic [COUNTER_WIDTH-1:0] stat_errors
);

    localparam int unsigned NPORT = 1 << ID_WIDTH;
    localparam logic [CNT_W:0] ONE_W = 1;
    localparam logic [CNT_W:0] SAT_W = (ONE_W << COUNTER_WIDTH) - ONE_W;
    localparam logic [CNT_W-1:0] SAT = SAT_W[CNT_W-1:0];

    // Counters are held at CNT_W bits; the ceiling is COUNTER_WIDTH ones.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] inc);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, inc};
        return (s > {1'b0, SAT}) ? SAT : s[CNT_W-1:0];
    endfunction

    counters_t cnt [NPORT];
    counters_t rd_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NPORT; i++) begin
                cnt[i] <= '0;
            end
        end else if (clear) begin
            for (int unsigned i = 0; i < NPORT; i++) begin
                cnt[i] <= '0;
            end
        end else if (commit_valid) begin
            cnt[commit_id].frames <= sat_add(cnt[commit_id].frames, CNT_W'(1));
            cnt[commit_id].bytes  <= sat_add(cnt[commit_id].bytes, CNT_W'(commit_len));
            cnt[commit_id].errors <= sat_add(cnt[commit_id].errors, CNT_W'(commit_err));
`ifdef FRAME_CHECKER_SEQ_CHECK_EN
            cnt[commit_id].seq_errors <= sat_add(cnt[commit_id].seq_errors,
                                                 CNT_W'(commit_seq_err));
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q <= '0;
        end else begin
            rd_q <= cnt[stat_sel];
        end
    end

    assign stat_frames = rd_q.frames[COUNTER_WIDTH-1:0];
    assign stat_bytes  = rd_q.bytes[COUNTER_WIDTH-1:0];
    assign stat_errors = rd_q.errors[COUNTER_WIDTH-1:0];
`ifdef FRAME_CHECKER_SEQ_CHECK_EN
    assign stat_seq_errors = rd_q.seq_errors[COUNTER_WIDTH-1:0];
`else
    logic unused_seq;
    assign unused_seq = ^rd_q.seq_errors;
`endif

endmodule

// File: rtl/frame_checker.sv
// Receive-side AXIS frame checker: per-port frame/byte/error statistics in a start/stop window.
// Define FRAME_CHECKER_SEQ_CHECK_EN to add per-port sequence-number checking.
module frame_checker
    import frame_checker_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 512,
    parameter int unsigned ID_WIDTH        = 3,
    parameter int unsigned COUNTER_WIDTH   = 64,
    parameter int unsigned MIN_FRAME_BYTES = 60
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      clear,
    output logic                      running,
    input  logic [DATA_WIDTH-1:0]     axis_s_data,
    input  logic [DATA_WIDTH/8-1:0]   axis_s_keep,
    input  logic                      axis_s_last,
    input  logic [DATA_WIDTH/8-1:0]   axis_s_user,
    input  logic [ID_WIDTH-1:0]       axis_s_id,
    input  logic                      axis_s_valid,
    output logic                      axis_s_ready,
    input  logic [ID_WIDTH-1:0]       stat_sel,
    output logic [COUNTER_WIDTH-1:0]  stat_frames,
    output logic [COUNTER_WIDTH-1:0]  stat_bytes,
`ifdef FRAME_CHECKER_SEQ_CHECK_EN
    output logic [COUNTER_WIDTH-1:0]  stat_seq_errors,
`endif
    output logic [COUNTER_WIDTH-1:0]  stat_errors
);

    state_t                state;
    logic                  running_q;
    logic                  ready_q;
    logic                  in_frame;
    logic [15:0]           len_q;
    logic                  err_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic                  elig_q;

    logic                  accept;
    logic                  first;
    logic [KEEP_MAX-1:0]   keep_ext;
    logic [7:0]            beat_bytes;
    logic [15:0]           len_base;
    logic [16:0]           len_sum;
    logic [15:0]           len_next;
    logic                  err_next;
    logic [ID_WIDTH-1:0]   id_cur;
    logic                  elig_cur;

    logic                  commit_v_q;
    logic [ID_WIDTH-1:0]   commit_id_q;
    logic [15:0]           commit_len_q;
    logic                  commit_err_q;

    assign accept     = axis_s_valid & ready_q;
    assign first      = accept & ~in_frame;
    assign keep_ext   = KEEP_MAX'(axis_s_keep);
    assign beat_bytes = popcount(keep_ext);
    assign len_base   = first ? '0 : len_q;
    assign len_sum    = {1'b0, len_base} + 17'(beat_bytes);
    assign len_next   = len_sum[16] ? '1 : len_sum[15:0];
    assign err_next   = (first ? 1'b0 : err_q) | (|axis_s_user);
    assign id_cur     = first ? axis_s_id : id_q;
    // Eligibility is decided once, on the first beat, from the window state at that moment.
    assign elig_cur   = first ? running_q : elig_q;

    assign running      = running_q;
    assign axis_s_ready = ready_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            running_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        state     <= RUN;
                        running_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (stop) begin
                        if (in_frame && !(accept && axis_s_last)) begin
                            state <= DRAIN;
                        end else begin
                            state     <= IDLE;
                            running_q <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (start && !stop) begin
                        state <= RUN;
                    end else if (accept && axis_s_last) begin
                        state     <= IDLE;
                        running_q <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q  <= 1'b0;
            in_frame <= 1'b0;
            len_q    <= '0;
            err_q    <= 1'b0;
            id_q     <= '0;
            elig_q   <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            if (accept) begin
                in_frame <= ~axis_s_last;
                len_q    <= len_next;
                err_q    <= err_next;
                id_q     <= id_cur;
                elig_q   <= elig_cur;
            end
        end
    end

`ifdef FRAME_CHECKER_SEQ_CHECK_EN
    localparam int unsigned NPORT = 1 << ID_WIDTH;

    logic [SEQ_W-1:0] exp_seq [NPORT];
    logic [NPORT-1:0] exp_vld;
    logic             seq_err_q;
    logic [SEQ_W-1:0] rx_seq;
    logic             seq_err_cur;

    assign rx_seq      = axis_s_data[SEQ_LSB +: SEQ_W];
    assign seq_err_cur = first ? (running_q && exp_vld[axis_s_id] &&
                                  (rx_seq != exp_seq[axis_s_id]))
                               : seq_err_q;

    // Match and mismatch both leave the expectation at received+1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NPORT; i++) begin
                exp_seq[i] <= '0;
            end
            exp_vld   <= '0;
            seq_err_q <= 1'b0;
        end else begin
            if (accept) begin
                seq_err_q <= seq_err_cur;
            end
            if (clear || start) begin
                exp_vld <= '0;
            end else if (first && running_q) begin
                exp_vld[axis_s_id] <= 1'b1;
                exp_seq[axis_s_id] <= rx_seq + 1'b1;
            end
        end
    end

    logic commit_seq_q;
    logic unused_data;
    assign unused_data = ^{axis_s_data[DATA_WIDTH-1:SEQ_LSB+SEQ_W], axis_s_data[SEQ_LSB-1:0]};
`else
    logic unused_data;
    assign unused_data = ^axis_s_data;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            commit_v_q   <= 1'b0;
            commit_id_q  <= '0;
            commit_len_q <= '0;
            commit_err_q <= 1'b0;
`ifdef FRAME_CHECKER_SEQ_CHECK_EN
            commit_seq_q <= 1'b0;
`endif
        end else begin
            commit_v_q   <= accept & axis_s_last & elig_cur;
            commit_id_q  <= id_cur;
            commit_len_q <= len_next;
            commit_err_q <= err_next | (len_next < 16'(MIN_FRAME_BYTES));
`ifdef FRAME_CHECKER_SEQ_CHECK_EN
            commit_seq_q <= seq_err_cur;
`endif
        end
    end

    frame_checker_counter_bank #(
        .ID_WIDTH      (ID_WIDTH),
        .COUNTER_WIDTH (COUNTER_WIDTH)
    ) u_bank (
        .clk             (clk),
        .rst             (rst),
        .clear           (clear),
        .commit_valid    (commit_v_q),
        .commit_id       (commit_id_q),
        .commit_len      (commit_len_q),
        .commit_err      (commit_err_q),
`ifdef FRAME_CHECKER_SEQ_CHECK_EN
        .commit_seq_err  (commit_seq_q),
`endif
        .stat_sel        (stat_sel),
        .stat_frames     (stat_frames),
        .stat_bytes      (stat_bytes),
`ifdef FRAME_CHECKER_SEQ_CHECK_EN
        .stat_seq_errors (stat_seq_errors),
`endif
        .stat_errors     (stat_errors)
    );

endmodule

// File: tb/tb_frame_checker.sv
// Directed self-checking bench for frame_checker; sequence checks run when FRAME_CHECKER_SEQ_CHECK_EN is defined.
module tb_frame_checker;

    localparam int unsigned DW = 512;
    localparam int unsigned IW = 3;
    localparam int unsigned CW = 64;
    localparam int unsigned KW = DW / 8;

    localparam logic [63:0] K_ALL = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] K_16  = 64'h0000_0000_0000_FFFF;
    localparam logic [63:0] K_40  = 64'h0000_00FF_FFFF_FFFF;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          clear = 1'b0;
    logic          running;
    logic [DW-1:0] axis_s_data = '0;
    logic [KW-1:0] axis_s_keep = '0;
    logic          axis_s_last = 1'b0;
    logic [KW-1:0] axis_s_user = '0;
    logic [IW-1:0] axis_s_id = '0;
    logic          axis_s_valid = 1'b0;
    logic          axis_s_ready;
    logic [IW-1:0] stat_sel = '0;
    logic [CW-1:0] stat_frames;
    logic [CW-1:0] stat_bytes;
    logic [CW-1:0] stat_errors;
`ifdef FRAME_CHECKER_SEQ_CHECK_EN
    logic [CW-1:0] stat_seq_errors;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    frame_checker #(
        .DATA_WIDTH      (DW),
        .ID_WIDTH        (IW),
        .COUNTER_WIDTH   (CW),
        .MIN_FRAME_BYTES (60)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .stop            (stop),
        .clear           (clear),
        .running         (running),
        .axis_s_data     (axis_s_data),
        .axis_s_keep     (axis_s_keep),
        .axis_s_last     (axis_s_last),
        .axis_s_user     (axis_s_user),
        .axis_s_id       (axis_s_id),
        .axis_s_valid    (axis_s_valid),
        .axis_s_ready    (axis_s_ready),
        .stat_sel        (stat_sel),
        .stat_frames     (stat_frames),
        .stat_bytes      (stat_bytes),
`ifdef FRAME_CHECKER_SEQ_CHECK_EN
        .stat_seq_errors (stat_seq_errors),
`endif
        .stat_errors     (stat_errors)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called 1 time unit after an edge; the beat is accepted on the next edge.
    task automatic beat(input logic [63:0] keep, input logic last, input logic [63:0] user,
                        input logic [IW-1:0] id, input logic [31:0] seq);
        axis_s_data           = '0;
        axis_s_data[383:352]  = seq;
        axis_s_keep           = keep;
        axis_s_last           = last;
        axis_s_user           = user;
        axis_s_id             = id;
        axis_s_valid          = 1'b1;
        @(posedge clk);
        #1;
        axis_s_valid = 1'b0;
        axis_s_last  = 1'b0;
        axis_s_user  = '0;
        axis_s_keep  = '0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
    endtask

    task automatic rd(input logic [IW-1:0] sel);
        stat_sel = sel;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 64'(axis_s_ready), 64'd0);
        check("rst_running", 64'(running), 64'd0);
        check("rst_frames", stat_frames, 64'd0);
        rst = 1'b0;
        idle(1);
        check("ready_after_rst", 64'(axis_s_ready), 64'd1);

        pulse_start();
        check("running_after_start", 64'(running), 64'd1);

        // 3-beat frame on id 2: 64+64+16 bytes
        beat(K_ALL, 1'b0, '0, 3'd2, 32'd0);
        beat(K_ALL, 1'b0, '0, 3'd2, 32'd0);
        beat(K_16,  1'b1, '0, 3'd2, 32'd0);
        idle(2);
        rd(3'd2);
        check("p2_frames", stat_frames, 64'd1);
        check("p2_bytes", stat_bytes, 64'd144);
        check("p2_errors", stat_errors, 64'd0);
        rd(3'd0);
        check("p0_frames_zero", stat_frames, 64'd0);
        rd(3'd7);
        check("p7_bytes_zero", stat_bytes, 64'd0);

        // runt on id 5
        beat(K_40, 1'b1, '0, 3'd5, 32'd0);
        idle(2);
        rd(3'd5);
        check("p5_frames", stat_frames, 64'd1);
        check("p5_bytes", stat_bytes, 64'd40);
        check("p5_runt_err", stat_errors, 64'd1);

        // user error on second beat, id 0
        beat(K_ALL, 1'b0, '0, 3'd0, 32'd0);
        beat(K_ALL, 1'b1, 64'h80, 3'd0, 32'd0);
        idle(2);
        rd(3'd0);
        check("p0_frames", stat_frames, 64'd1);
        check("p0_bytes", stat_bytes, 64'd128);
        check("p0_user_err", stat_errors, 64'd1);

        // stop mid-frame on id 1: window drains, frame still counted
        beat(K_ALL, 1'b0, '0, 3'd1, 32'd0);
        pulse_stop();
        check("drain_running", 64'(running), 64'd1);
        beat(K_ALL, 1'b1, '0, 3'd1, 32'd0);
        check("drain_done_running", 64'(running), 64'd0);
        idle(2);
        rd(3'd1);
        check("p1_frames", stat_frames, 64'd1);
        check("p1_bytes", stat_bytes, 64'd128);

        // start mid-frame on id 6: frame skipped
        beat(K_ALL, 1'b0, '0, 3'd6, 32'd0);
        pulse_start();
        beat(K_ALL, 1'b1, '0, 3'd6, 32'd0);
        check("restart_running", 64'(running), 64'd1);
        idle(2);
        rd(3'd6);
        check("p6_skipped", stat_frames, 64'd0);

        // clear on the same edge the commit lands
        beat(K_ALL, 1'b1, '0, 3'd4, 32'd0);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        idle(1);
        rd(3'd4);
        check("clear_drops_commit", stat_frames, 64'd0);
        rd(3'd2);
        check("clear_p2_frames", stat_frames, 64'd0);
        beat(K_ALL, 1'b1, '0, 3'd4, 32'd0);
        idle(2);
        rd(3'd4);
        check("p4_after_clear", stat_frames, 64'd1);
        check("p4_bytes", stat_bytes, 64'd64);
        check("p4_errors", stat_errors, 64'd0);

`ifdef FRAME_CHECKER_SEQ_CHECK_EN
        beat(K_ALL, 1'b1, '0, 3'd3, 32'd10);
        beat(K_ALL, 1'b1, '0, 3'd3, 32'd11);
        beat(K_ALL, 1'b1, '0, 3'd3, 32'd13);
        beat(K_ALL, 1'b1, '0, 3'd3, 32'd14);
        idle(2);
        rd(3'd3);
        check("p3_seq_frames", stat_frames, 64'd4);
        check("p3_seq_errors", stat_seq_errors, 64'd1);
`endif

        // async reset mid-frame
        beat(K_ALL, 1'b0, '0, 3'd3, 32'd20);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_running", 64'(running), 64'd0);
        check("midrst_ready", 64'(axis_s_ready), 64'd0);
        check("midrst_frames", stat_frames, 64'd0);
        #1;
        rst = 1'b0;
        idle(2);
        beat(K_ALL, 1'b1, '0, 3'd3, 32'd21);
        idle(2);
        rd(3'd3);
        check("postrst_p3_frames", stat_frames, 64'd0);
        rd(3'd4);
        check("postrst_p4_frames", stat_frames, 64'd0);
        check("postrst_running", 64'(running), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
